led_scan_controller: RTL and testbench

Sequencer that sits directly upstream of led_array_driver and produces its ena, x and cells inputs.
- Walks x through 0..N-1 with a programmable on-time per column and a blanking gap between columns to suppress ghosting.
- Double-buffers the N*N cell image from the game-of-life core through a valid/ready handshake.
- Swaps the displayed image only at frame boundaries, so a generation is never shown torn.

---
 rtl/led_scan_controller.sv | 143 ++++++++++++++
 tb/tb_led_scan_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// Column scan sequencer for led_array_driver with a double-buffered image; ena/x/cells are registered, swap at frame end.
// Backpressure: cells_ready stays low while a shadow image is pending. LED_SCAN_BRIGHTNESS_EN adds a 4-bit PWM brightness input.
module led_scan_controller #(
    parameter int N           = 5,
    parameter int ON_TICKS    = 1000,
    parameter int BLANK_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena_in,
    input  logic [N*N-1:0]       cells_in,
    input  logic                 cells_valid,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [3:0]           brightness,
`endif
    output logic                 cells_ready,
    output logic [N*N-1:0]       cells,
    output logic [$clog2(N):0]   x,
    output logic                 ena,
    output logic                 frame_done
);

    localparam int XW   = $clog2(N) + 1;
    localparam int TMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    // At least 4 bits so the brightness compare always has tick bits to look at.
    localparam int TW   = ($clog2(TMAX) < 4) ? 4 : $clog2(TMAX);

    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_tick;
    logic [XW-1:0]     r_x;
    logic              r_ena;
    logic              r_frame_done;
    logic [N*N-1:0]    r_shadow;
    logic              r_shadow_full;
    logic [N*N-1:0]    r_cells;

    logic [TW-1:0]     w_tick_inc;
    logic              w_ena_on_next;
    logic              w_swap;
    logic              w_accept;

    assign w_tick_inc = r_tick + 1'b1;

`ifdef LED_SCAN_BRIGHTNESS_EN
    assign w_ena_on_next = (w_tick_inc[3:0] <= brightness);
`else
    assign w_ena_on_next = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_x          <= '0;
            r_ena        <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (!ena_in) begin
                r_state <= S_IDLE;
                r_tick  <= '0;
                r_x     <= '0;
                r_ena   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_BLANK;
                        r_tick  <= '0;
                        r_ena   <= 1'b0;
                    end
                    S_BLANK: begin
                        if (r_tick == BLANK_LAST) begin
                            // Tick 0 of ON always satisfies the brightness compare.
                            r_state <= S_ON;
                            r_tick  <= '0;
                            r_ena   <= 1'b1;
                        end else begin
                            r_tick <= w_tick_inc;
                        end
                    end
                    S_ON: begin
                        if (r_tick == ON_LAST) begin
                            r_state <= S_BLANK;
                            r_tick  <= '0;
                            r_ena   <= 1'b0;
                            if (r_x == X_LAST) begin
                                r_x          <= '0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                        end else begin
                            r_tick <= w_tick_inc;
                            r_ena  <= w_ena_on_next;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tick  <= '0;
                        r_x     <= '0;
                        r_ena   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Swap decision uses the registered frame_done, so an image accepted on the
    // frame_done cycle itself waits for the following frame.
    assign w_swap   = r_shadow_full && ((r_state == S_IDLE) || r_frame_done);
    assign w_accept = cells_valid && !r_shadow_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_cells       <= '0;
        end else if (w_swap) begin
            r_cells       <= r_shadow;
            r_shadow_full <= 1'b0;
        end else if (w_accept) begin
            r_shadow      <= cells_in;
            r_shadow_full <= 1'b1;
        end
    end

    assign cells_ready = !r_shadow_full;
    assign cells       = r_cells;
    assign x           = r_x;
    assign ena         = r_ena;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller (N=5, ON_TICKS=8, BLANK_TICKS=2); displayed images are scoreboarded.
module tb_led_scan_controller;

    localparam int N     = 5;
    localparam int ON    = 8;
    localparam int BLANK = 2;
    localparam int COL   = ON + BLANK;
    localparam int FRAME = N * COL;

    logic              clk;
    logic              rst;
    logic              ena_in;
    logic [N*N-1:0]    cells_in;
    logic              cells_valid;
    logic              cells_ready;
    logic [N*N-1:0]    cells;
    logic [$clog2(N):0] x;
    logic              ena;
    logic              frame_done;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [3:0]        brightness;
`endif

    led_scan_controller #(.N(N), .ON_TICKS(ON), .BLANK_TICKS(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena_in      (ena_in),
        .cells_in    (cells_in),
        .cells_valid (cells_valid),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .cells_ready (cells_ready),
        .cells       (cells),
        .x           (x),
        .ena         (ena),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             n_cmp = 0;
    int             n_mis = 0;
    int             kb;
    logic [31:0]    prev_x;
    logic [N*N-1:0] exp_q[$];
    logic [N*N-1:0] mon_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected scan waveform, indexed by cycles since entering BLANK from IDLE.
    function automatic logic [31:0] exp_ena(input int k);
        return ((k % COL) >= BLANK) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_x(input int k);
        return 32'((k / COL) % N);
    endfunction

    function automatic logic [31:0] exp_fd(input int k);
        return (k > 0 && (k % FRAME) == 0) ? 32'd1 : 32'd0;
    endfunction

    task automatic scan(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("ena", 32'(ena), exp_ena(kb));
            check("x", 32'(x), exp_x(kb));
            check("frame_done", 32'(frame_done), exp_fd(kb));
            if (32'(x) !== prev_x) check("ena_low_on_x_change", 32'(ena), 32'd0);
            prev_x = 32'(x);
            kb++;
        end
    endtask

    // Scoreboard: every change of the displayed image must match the next queued image.
    always @(negedge clk) begin
        if (rst) begin
            mon_prev = cells;
        end else if (cells !== mon_prev) begin
            if (exp_q.size() == 0) begin
                check("cells_unexpected_change", 32'(cells), 32'(mon_prev));
            end else begin
                check("cells_scoreboard", 32'(cells), 32'(exp_q.pop_front()));
            end
            mon_prev = cells;
        end
    end

    initial begin
        rst         = 1'b1;
        ena_in      = 1'b0;
        cells_in    = '0;
        cells_valid = 1'b0;
`ifdef LED_SCAN_BRIGHTNESS_EN
        brightness  = 4'hF;
`endif
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ena", 32'(ena), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_cells", 32'(cells), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_cells_ready", 32'(cells_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ena", 32'(ena), 32'd0);

        // Scan pattern over one frame plus a column
        ena_in = 1'b1;
        kb     = 0;
        prev_x = 32'd0;
        scan(61);

        // Mid-frame image held in shadow until frame_done
        cells_in    = 25'h1;
        cells_valid = 1'b1;
        exp_q.push_back(25'h1);
        scan(1);
        check("pend_ready", 32'(cells_ready), 32'd0);
        check("pend_cells", 32'(cells), 32'd0);
        cells_valid = 1'b0;
        scan(1);
        cells_in    = 25'h2;
        cells_valid = 1'b1;
        scan(1);
        cells_valid = 1'b0;
        check("second_valid_ignored", 32'(cells_ready), 32'd0);
        scan(37);
        check("fd_cycle_cells", 32'(cells), 32'd0);
        check("fd_cycle_ready", 32'(cells_ready), 32'd0);
        scan(1);
        check("swap_cells", 32'(cells), 32'h1);
        check("swap_ready", 32'(cells_ready), 32'd1);

        // Accept during the frame_done cycle: shown only after the next frame
        scan(49);
        check("fd_at_150", 32'(frame_done), 32'd1);
        cells_in    = 25'h3;
        cells_valid = 1'b1;
        exp_q.push_back(25'h3);
        scan(1);
        cells_valid = 1'b0;
        check("fd_accept_ready", 32'(cells_ready), 32'd0);
        check("fd_accept_cells", 32'(cells), 32'h1);
        scan(49);
        check("late_cells_still_old", 32'(cells), 32'h1);
        scan(1);
        check("late_swap_cells", 32'(cells), 32'h3);
        check("late_swap_ready", 32'(cells_ready), 32'd1);

        // Drop ena_in during ON at x=2
        scan(24);
        check("drop_pre_x", 32'(x), 32'd2);
        check("drop_pre_ena", 32'(ena), 32'd1);
        ena_in = 1'b0;
        @(negedge clk);
        check("drop_ena", 32'(ena), 32'd0);
        check("drop_x", 32'(x), 32'd0);
        check("drop_frame_done", 32'(frame_done), 32'd0);

        // IDLE transfer reaches cells two edges later
        cells_in    = 25'h4;
        cells_valid = 1'b1;
        exp_q.push_back(25'h4);
        @(negedge clk);
        cells_valid = 1'b0;
        check("idle_acc_ready", 32'(cells_ready), 32'd0);
        check("idle_acc_cells", 32'(cells), 32'h3);
        @(negedge clk);
        check("idle_swap_cells", 32'(cells), 32'h4);
        check("idle_swap_ready", 32'(cells_ready), 32'd1);

        // Re-enable: blank, then x=0 on
        ena_in = 1'b1;
        kb     = 0;
        prev_x = 32'd0;
        scan(12);

        // Reset during ON at x=3 with the shadow full
        cells_in    = 25'h5;
        cells_valid = 1'b1;
        exp_q.push_back(25'h5);
        scan(1);
        cells_valid = 1'b0;
        check("shadow_full_ready", 32'(cells_ready), 32'd0);
        scan(23);
        check("pre_rst_x", 32'(x), 32'd3);
        check("pre_rst_ena", 32'(ena), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ena", 32'(ena), 32'd0);
        check("mid_rst_x", 32'(x), 32'd0);
        check("mid_rst_cells", 32'(cells), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_ready", 32'(cells_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst    = 1'b0;
        kb     = 0;
        prev_x = 32'd0;
        scan(55);
        check("discarded_shadow_cells", 32'(cells), 32'd0);
        check("post_rst_ready", 32'(cells_ready), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
